// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
// Shared constants and types for the two-port ALU arbiter:
//   DATA_W  - operand/result width
//   OP_W    - opcode width
//   OP_NOP  - opcode presented to the EXE stage when no operation is running
//   state_t - arbiter FSM state encoding
package alu_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
// Bundles the requester handshake and the EXE-stage bus of alu_arbiter.
//   slave  - the arbiter side: requests, operands and EXE results in;
//            grants, done pulses, captured result/flags and EXE drive out
//   master - the environment side (requesters plus EXE stage)
interface alu_arbiter_if;

    logic                               req0, req1;
    logic [alu_arbiter_pkg::OP_W-1:0]   op0, op1;
    logic [alu_arbiter_pkg::DATA_W-1:0] a0, b0, a1, b1;
    logic                               gnt0, gnt1;
    logic                               done0, done1;
    logic [alu_arbiter_pkg::DATA_W-1:0] res;
    logic                               fn, fz;
    logic [alu_arbiter_pkg::DATA_W-1:0] Ira, Irb;
    logic [alu_arbiter_pkg::OP_W-1:0]   OPALU;
    logic                               NFCR, ZFCR;
    logic [alu_arbiter_pkg::DATA_W-1:0] OALUD;
    logic                               IFgn, IFgz;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, OALUD, IFgn, IFgz,
        output gnt0, gnt1, done0, done1, res, fn, fz, Ira, Irb, OPALU, NFCR, ZFCR
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, OALUD, IFgn, IFgz,
        input  gnt0, gnt1, done0, done1, res, fn, fz, Ira, Irb, OPALU, NFCR, ZFCR
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin pick, purely combinational.
//   req0, req1 - requests
//   last       - port granted most recently
//   winner     - selected port (only meaningful when req0|req1)
// A lone requester always wins; on a tie the port other than 'last' wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    assign winner = req1 & (~req0 | ~last);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one EXE stage between two requesters. A request is accepted in IDLE,
// its opcode/operands are latched and driven to the EXE stage for EXE_LAT
// cycles, the EXE result/flags are captured on entry to DONE and a one-cycle
// done pulse is returned to the granted port.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-low reset
//   bus - alu_arbiter_if.slave (requester handshake + EXE stage bus)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int EXE_LAT = 1   // legal 1..3
) (
    input  logic               clk,
    input  logic               rst,
    alu_arbiter_if.slave       bus
);

    // Counter starts at EXE_LAT-1 so EXEC lasts exactly EXE_LAT cycles.
    localparam logic [1:0] CNT_INIT = 2'(EXE_LAT - 1);

    state_t              state_q, state_d;
    logic                win_q;     // port owning the operation in flight
    logic                last_q;    // last accepted port, for round robin
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic [1:0]          cnt_q;
    logic [DATA_W-1:0]   res_q;
    logic                fn_q, fz_q;

    logic                winner;
    logic                accept;
    logic                capture;

    rr_arbiter2 u_rr (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_q),
        .winner (winner)
    );

    // Next state and all outputs; everything is decoded from registered
    // state, so reset forces every output low immediately.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        bus.gnt0  = 1'b0;
        bus.gnt1  = 1'b0;
        bus.done0 = 1'b0;
        bus.done1 = 1'b0;
        bus.Ira   = '0;
        bus.Irb   = '0;
        bus.OPALU = OP_NOP;
        bus.NFCR  = 1'b0;
        bus.ZFCR  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.Ira   = a_q;
                bus.Irb   = b_q;
                bus.OPALU = op_q;
                bus.NFCR  = 1'b1;
                bus.ZFCR  = 1'b1;
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done0 = ~win_q;
                bus.done1 = win_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q == ST_EXEC || state_q == ST_DONE) begin
            bus.gnt0 = ~win_q;
            bus.gnt1 = win_q;
        end
    end

    assign bus.res = res_q;
    assign bus.fn  = fn_q;
    assign bus.fz  = fz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            last_q  <= 1'b1;    // port 0 wins the first tie
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= 2'd0;
            res_q   <= '0;
            fn_q    <= 1'b0;
            fz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                win_q  <= winner;
                last_q <= winner;
                op_q   <= winner ? bus.op1 : bus.op0;
                a_q    <= winner ? bus.a1  : bus.a0;
                b_q    <= winner ? bus.b1  : bus.b0;
                cnt_q  <= CNT_INIT;
            end else if (state_q == ST_EXEC && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (capture) begin
                res_q <= bus.OALUD;
                fn_q  <= bus.IFgn;
                fz_q  <= bus.IFgz;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
// Randomized plus directed bench for alu_arbiter with an EXE stub
// (op 1 = a+b, op 2 = a-b, others 0). A cycle-level reference model
// tracks acceptance, busy time and captured results; accepted operations
// are queued and a separate negedge monitor compares every done pulse
// and the per-cycle grant/done/EXE-bus/result state.
module tb_alu_arbiter;

    localparam int EXE_LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.EXE_LAT(EXE_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Requester drive
    logic       req_s [2];
    logic [3:0] op_s  [2];
    logic [7:0] a_s   [2];
    logic [7:0] b_s   [2];

    assign bus.req0 = req_s[0];
    assign bus.req1 = req_s[1];
    assign bus.op0  = op_s[0];
    assign bus.op1  = op_s[1];
    assign bus.a0   = a_s[0];
    assign bus.b0   = b_s[0];
    assign bus.a1   = a_s[1];
    assign bus.b1   = b_s[1];

    // EXE stub (combinational, matches EXE_LAT = 1)
    assign bus.OALUD = (bus.OPALU == 4'd1) ? bus.Ira + bus.Irb :
                       (bus.OPALU == 4'd2) ? bus.Ira - bus.Irb : 8'd0;
    assign bus.IFgn  = bus.OALUD[7];
    assign bus.IFgz  = (bus.OALUD == 8'd0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // m_busy counts cycles left before the arbiter is idle again
    int         m_busy = 0;
    logic       m_last = 1'b1;
    logic       m_win  = 1'b0;
    logic [3:0] m_op   = '0;
    logic [7:0] m_a    = '0;
    logic [7:0] m_b    = '0;
    logic [9:0] m_res  = '0;    // {fn, fz, res}
    logic [9:0] m_cap  = '0;
    logic [10:0] sb [$];        // {port, fn, fz, res}

    function automatic logic [9:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = (op == 4'd1) ? 8'(a + b) : (op == 4'd2) ? 8'(a - b) : 8'd0;
        return {r[7], (r == 8'd0), r};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_busy = 0;
                m_last = 1'b1;
                m_cap  = '0;
                sb.delete();
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 1) m_cap = m_res;
            end else if (req_s[0] || req_s[1]) begin
                m_win  = (req_s[0] && req_s[1]) ? ~m_last : req_s[1];
                m_last = m_win;
                m_op   = op_s[m_win];
                m_a    = a_s[m_win];
                m_b    = b_s[m_win];
                m_res  = alu_ref(m_op, m_a, m_b);
                m_busy = EXE_LAT + 1;
                sb.push_back({m_win, m_res});
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [3:0]  exp_gd;
        logic [21:0] exp_exe;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            exp_gd = '0;
            if (m_busy > 0) exp_gd[3:2] = m_win ? 2'b01 : 2'b10;
            if (m_busy == 1) exp_gd[1:0] = m_win ? 2'b01 : 2'b10;
            check("gnt_done", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'(exp_gd));
            exp_exe = (m_busy > 1) ? {m_a, m_b, m_op, 2'b11} : 22'd0;
            check("exe_bus", {bus.Ira, bus.Irb, bus.OPALU, bus.NFCR, bus.ZFCR}, 32'(exp_exe));
            check("res_hold", {bus.fn, bus.fz, bus.res}, 32'(m_cap));
            if (bus.done0 || bus.done1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("txn", {bus.done1, bus.fn, bus.fz, bus.res}, 32'(e));
                    $display("txn port%0d res=%02h fn=%0d fz=%0d", bus.done1, bus.res, bus.fn, bus.fz);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_op(input int p, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        op_s[p] = op;
        a_s[p]  = a;
        b_s[p]  = b;
    endtask

    // Raise requests for the ports in mask, hold each until its done pulse.
    // chg_a: overwrite a0 with 9 on the first cycle gnt0 is seen.
    task automatic serve(input logic [1:0] mask, input logic chg_a);
        logic [1:0] pend;
        logic       chg;
        int         cyc;
        pend = mask;
        chg  = chg_a;
        @(negedge clk);
        if (mask[0]) req_s[0] = 1'b1;
        if (mask[1]) req_s[1] = 1'b1;
        cyc = 0;
        while (pend != 2'b00 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (chg && bus.gnt0) begin
                a_s[0] = 8'd9;
                chg    = 1'b0;
            end
            if (pend[0] && bus.done0) begin req_s[0] = 1'b0; pend[0] = 1'b0; end
            if (pend[1] && bus.done1) begin req_s[1] = 1'b0; pend[1] = 1'b0; end
        end
        check("serve_timeout", 32'(pend), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res, bus.fn, bus.fz,
                             bus.NFCR, bus.ZFCR, bus.OPALU}, 32'd0);
        #1 rst = 1'b1;
    endtask

    initial begin
        logic [1:0] rbusy;
        int         cyc;
        req_s[0] = 1'b0; req_s[1] = 1'b0;
        set_op(0, 4'd0, 8'd0, 8'd0);
        set_op(1, 4'd0, 8'd0, 8'd0);
        rbusy = 2'b00;

        repeat (3) @(negedge clk);
        check("reset_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.res, bus.fn, bus.fz,
                             bus.Ira, bus.NFCR, bus.ZFCR}, 32'd0);
        #1 rst = 1'b1;

        // single add, subtract to zero, subtract to negative, operand change after grant
        set_op(0, 4'd1, 8'd2, 8'd2); serve(2'b01, 1'b0);
        set_op(0, 4'd2, 8'd3, 8'd3); serve(2'b01, 1'b0);
        set_op(0, 4'd2, 8'd3, 8'd4); serve(2'b01, 1'b0);
        set_op(0, 4'd1, 8'd2, 8'd3); serve(2'b01, 1'b1);

        // tie from reset: port 0 first, then port 1; repeated ties alternate
        apply_reset();
        set_op(0, 4'd1, 8'd5, 8'd7);
        set_op(1, 4'd2, 8'd6, 8'd3);
        serve(2'b11, 1'b0);
        serve(2'b11, 1'b0);
        serve(2'b11, 1'b0);

        // reset during EXEC aborts; held req1 served after release
        set_op(1, 4'd1, 8'd7, 8'd1);
        @(negedge clk);
        req_s[1] = 1'b1;
        cyc = 0;
        while (!bus.gnt1 && cyc < 10) begin @(negedge clk); cyc++; end
        check("gnt1_seen", 32'(bus.gnt1), 32'd1);
        apply_reset();
        serve(2'b10, 1'b0);

        // randomized phase: requests, mid-flight operand changes and req drops
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                logic g, d;
                g = p ? bus.gnt1  : bus.gnt0;
                d = p ? bus.done1 : bus.done0;
                if (!rbusy[p]) begin
                    if (c < 1550 && $urandom_range(0, 99) < 40) begin
                        set_op(p, 4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
                        req_s[p] = 1'b1;
                        rbusy[p] = 1'b1;
                    end
                end else if (d) begin
                    req_s[p] = 1'b0;
                    rbusy[p] = 1'b0;
                end else if (g) begin
                    if ($urandom_range(0, 99) < 25)
                        set_op(p, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
                    if ($urandom_range(0, 99) < 10) req_s[p] = 1'b0;
                end
            end
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: EXE_LAT, 1, EXE-stage cycles from operand drive to valid OALUD/IFgn/IFgz (legal 1..3).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req0, req1  in  1  requester 0/1 operation request, held until done
- op0, op1  in  4  requester opcode
- a0, b0, a1, b1  in  8  requester operands
- gnt0, gnt1  out  1  grant, high from acceptance through the done cycle
- done0, done1  out  1  one-cycle result-valid pulse
- res  out  8  captured result
- fn, fz  out  1  captured negative/zero flags
- Ira, Irb  out  8  operands to EXE stage
- OPALU  out  4  opcode to EXE stage
- NFCR, ZFCR  out  1  EXE flag-update enables
- OALUD  in  8  EXE result
- IFgn, IFgz  in  1  EXE negative/zero flags
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE.
REQ-005 IDLE: on an edge with req0|req1, SHALL pick a winner, latch its op/a/b, assert its gnt, and enter EXEC; otherwise SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin: a single requester always wins; with both requesting, the port not granted last wins; the last-grant pointer SHALL update only on acceptance.
REQ-007 EXEC: SHALL drive Ira/Irb/OPALU from the latched values and NFCR=ZFCR=1 for exactly EXE_LAT cycles, then enter DONE.
REQ-008 On entry to DONE, res/fn/fz SHALL capture OALUD/IFgn/IFgz; res/fn/fz SHALL hold until the next capture.
REQ-009 DONE: SHALL assert done for the granted port for exactly one cycle, then return to IDLE, deasserting gnt.
REQ-010 Latency: req sampled at edge T -> gnt high after T -> done high after T+EXE_LAT -> IDLE after T+EXE_LAT+1; back-to-back throughput is EXE_LAT+2 cycles per operation.
REQ-011 Outside EXEC, Ira=Irb=0, OPALU=0, and NFCR=ZFCR=0.
REQ-012 Requester inputs changing after acceptance SHALL NOT affect the operation in flight.
REQ-013 A requester dropping req mid-operation SHALL NOT abort it; done SHALL still pulse and res SHALL still update.
REQ-014 A request arriving during EXEC/DONE SHALL wait; it SHALL be arbitrated in the next IDLE cycle.
REQ-015 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.

Reset
REQ-016 While rst=0, SHALL force state IDLE and all outputs to 0, with the last-grant pointer = port 1 so port 0 wins the first tie.
REQ-017 Reset mid-EXEC/DONE SHALL abort the operation with no done pulse and no res/flag capture.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, OP_NOP=4'd0, and the data-width (8) and opcode-width (4) constants.
REQ-019 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req0, req1, last; output winner).
REQ-020 EXE_LAT countdown SHALL use a 2-bit counter local to alu_arbiter.

Verification (EXE stub: op 1 = a+b, op 2 = a-b; EXE_LAT=1)
REQ-021 req0, op0=1, a0=2, b0=2 -> gnt0 one cycle later, OPALU=1 for 1 cycle, done0 pulse with res=4, fn=0, fz=0.
REQ-022 req0 and req1 together from reset (op1=2, a1=6, b1=3) -> port 0 served first, then port 1 with res=3; total 6 cycles.
REQ-023 Both requests held continuously -> grants alternate 0,1,0,1; gnt0 and gnt1 never high together.
REQ-024 op0=2, a0=3, b0=3 -> res=0, fz=1; op0=2, a0=3, b0=4 -> res=8'hFF, fn=1.
REQ-025 rst pulled low during EXEC -> no done pulse, all outputs 0; after release, a held req1 is served normally.
REQ-026 a0 changed to 9 one cycle after gnt0 -> res reflects the latched operand, not 9.
